// File: rtl/cpu_controller_pkg.sv
// Shared CPU definitions: opcode encodings, controller state encodings and
// opcode class helpers, also used by the instruction register and ALU.
package cpu_controller_pkg;

  localparam logic [2:0] OP_HLT  = 3'b000;
  localparam logic [2:0] OP_SKZ  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_ANDD = 3'b011;
  localparam logic [2:0] OP_XORR = 3'b100;
  localparam logic [2:0] OP_LDA  = 3'b101;
  localparam logic [2:0] OP_STO  = 3'b110;
  localparam logic [2:0] OP_JMP  = 3'b111;

  // Codes 10..15 are unused and decode as IDLE.
  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_S0     = 4'd1,
    ST_S1     = 4'd2,
    ST_S2     = 4'd3,
    ST_S3     = 4'd4,
    ST_S4     = 4'd5,
    ST_S5     = 4'd6,
    ST_S6     = 4'd7,
    ST_S7     = 4'd8,
    ST_HALTED = 4'd9
  } state_t;

  function automatic logic is_alu_op(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_ANDD) || (op == OP_XORR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/cpu_controller.sv
// Eight-phase fetch/execute sequencer for the simple accumulator CPU.
// Outputs are decoded from the current state only, so they hold for a full cycle.
module cpu_controller
  import cpu_controller_pkg::*;
#(
  parameter int OP_W = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ena,
  input  logic [OP_W-1:0] opcode,
  input  logic            zero,
  output logic            inc_pc,
  output logic            load_ir,
  output logic            rd,
  output logic            wr,
  output logic            load_acc,
  output logic            load_pc,
  output logic            datactl_ena,
  output logic            halt,
  output state_t          state_o
);

  state_t     state_q, state_d;
  logic       zero_q, zero_d;
  logic [2:0] op;
  logic       is_alu, is_sto, is_jmp, is_skz;

  assign op      = opcode[2:0];
  assign is_alu  = is_alu_op(op);
  assign is_sto  = (op == OP_STO);
  assign is_jmp  = (op == OP_JMP);
  assign is_skz  = (op == OP_SKZ);
  assign state_o = state_q;

  // The skip decision is frozen at S4 so a late zero change cannot alter it.
  assign zero_d = (state_q == ST_S4) ? zero : zero_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      zero_q  <= zero_d;
    end
  end

  // ena is only looked at in IDLE and S7, so an instruction always runs to S7.
  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE:   state_d = ena ? ST_S0 : ST_IDLE;
      ST_S0:     state_d = ST_S1;
      ST_S1:     state_d = ST_S2;
      ST_S2:     state_d = ST_S3;
      ST_S3:     state_d = (op == OP_HLT) ? ST_HALTED : ST_S4;
      ST_S4:     state_d = ST_S5;
      ST_S5:     state_d = ST_S6;
      ST_S6:     state_d = ST_S7;
      ST_S7:     state_d = ena ? ST_S0 : ST_IDLE;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    inc_pc      = 1'b0;
    load_ir     = 1'b0;
    rd          = 1'b0;
    wr          = 1'b0;
    load_acc    = 1'b0;
    load_pc     = 1'b0;
    datactl_ena = 1'b0;
    halt        = 1'b0;
    case (state_q)
      ST_S0, ST_S1: begin
        load_ir = 1'b1;
        rd      = 1'b1;
        inc_pc  = 1'b1;
      end
      ST_S4: begin
        rd          = is_alu;
        datactl_ena = is_sto;
        load_pc     = is_jmp;
      end
      ST_S5: begin
        rd          = is_alu;
        load_acc    = is_alu;
        datactl_ena = is_sto;
        load_pc     = is_jmp;
        inc_pc      = is_skz & zero_q;
      end
      ST_S6: begin
        datactl_ena = is_sto;
        wr          = is_sto;
        rd          = is_alu;
      end
      ST_S7: begin
        datactl_ena = is_sto;
        inc_pc      = is_skz & zero_q;
      end
      ST_HALTED: halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller: per-state output and sequencing checks
// with hand-computed expectations for each opcode class, ena and reset cases.
module tb_cpu_controller;
  import cpu_controller_pkg::*;

  localparam logic [7:0] O_INC = 8'h01;
  localparam logic [7:0] O_IR  = 8'h02;
  localparam logic [7:0] O_RD  = 8'h04;
  localparam logic [7:0] O_WR  = 8'h08;
  localparam logic [7:0] O_ACC = 8'h10;
  localparam logic [7:0] O_PC  = 8'h20;
  localparam logic [7:0] O_DCT = 8'h40;
  localparam logic [7:0] O_HLT = 8'h80;
  localparam logic [7:0] O_FETCH = O_IR | O_RD | O_INC;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [2:0] opcode = OP_LDA;
  logic       zero = 1'b0;
  logic       inc_pc, load_ir, rd, wr, load_acc, load_pc, datactl_ena, halt;
  state_t     state_o;
  logic [7:0] outs;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cpu_controller #(.OP_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .opcode(opcode), .zero(zero),
    .inc_pc(inc_pc), .load_ir(load_ir), .rd(rd), .wr(wr), .load_acc(load_acc),
    .load_pc(load_pc), .datactl_ena(datactl_ena), .halt(halt), .state_o(state_o)
  );

  assign outs = {halt, datactl_ena, load_pc, load_acc, wr, rd, load_ir, inc_pc};

  task automatic chk(input string tag, input state_t st, input logic [7:0] eo);
    n_cmp++;
    assert (state_o === st) else begin
      n_err++;
      $error("FAIL %s state observed=%0d expected=%0d", tag, state_o, st);
    end
    n_cmp++;
    assert (outs === eo) else begin
      n_err++;
      $error("FAIL %s outs observed=%b expected=%b", tag, outs, eo);
    end
  endtask

  task automatic cyc(input string tag, input state_t st, input logic [7:0] eo);
    @(posedge clk);
    #1;
    chk(tag, st, eo);
  endtask

  // Runs one instruction starting from IDLE/S7 with ena=1; e4..e7 are the
  // expected outputs in S4..S7. zero is set to z4 during S4, z_late from S6.
  task automatic instr(input string tag, input logic [2:0] op,
                       input logic [7:0] e4, input logic [7:0] e5,
                       input logic [7:0] e6, input logic [7:0] e7,
                       input logic z4, input logic z_late, input logic drop_ena);
    logic [7:0] exp_o [8];
    exp_o[0] = O_FETCH; exp_o[1] = O_FETCH; exp_o[2] = 8'h00; exp_o[3] = 8'h00;
    exp_o[4] = e4; exp_o[5] = e5; exp_o[6] = e6; exp_o[7] = e7;
    opcode = op;
    for (int i = 0; i < 8; i++) begin
      cyc($sformatf("%s_s%0d", tag, i), state_t'(int'(ST_S0) + i), exp_o[i]);
      if (i == 2 && drop_ena) ena = 1'b0;
      if (i == 3) zero = z4;
      if (i == 5) zero = z_late;
      if (i == 3 && op == OP_HLT) break;
    end
  endtask

  initial begin
    // Reset held with ena=1: everything quiet, including across clock edges.
    rst_n = 1'b0; ena = 1'b1; opcode = OP_LDA; zero = 1'b0;
    #2;
    chk("rst_async", ST_IDLE, 8'h00);
    cyc("rst_edge1", ST_IDLE, 8'h00);
    cyc("rst_edge2", ST_IDLE, 8'h00);
    rst_n = 1'b1;

    instr("lda", OP_LDA, O_RD, O_RD | O_ACC, O_RD, 8'h00, 1'b0, 1'b0, 1'b0);
    instr("add", OP_ADD, O_RD, O_RD | O_ACC, O_RD, 8'h00, 1'b1, 1'b1, 1'b0);
    instr("sto", OP_STO, O_DCT, O_DCT, O_DCT | O_WR, O_DCT, 1'b0, 1'b0, 1'b0);
    instr("skz_z1", OP_SKZ, 8'h00, O_INC, 8'h00, O_INC, 1'b1, 1'b0, 1'b0);
    instr("skz_late", OP_SKZ, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    instr("jmp", OP_JMP, O_PC, O_PC, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    instr("andd", OP_ANDD, O_RD, O_RD | O_ACC, O_RD, 8'h00, 1'b0, 1'b0, 1'b0);
    instr("xorr", OP_XORR, O_RD, O_RD | O_ACC, O_RD, 8'h00, 1'b0, 1'b0, 1'b0);

    // ena dropped in S2: instruction completes, then parks in IDLE.
    instr("sto_drop", OP_STO, O_DCT, O_DCT, O_DCT | O_WR, O_DCT, 1'b0, 1'b0, 1'b1);
    cyc("idle_after_drop", ST_IDLE, 8'h00);
    cyc("idle_hold", ST_IDLE, 8'h00);
    ena = 1'b1;
    instr("lda_resume", OP_LDA, O_RD, O_RD | O_ACC, O_RD, 8'h00, 1'b0, 1'b0, 1'b0);

    // HLT: halted after S3 and sticky regardless of ena.
    instr("hlt", OP_HLT, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    cyc("halted0", ST_HALTED, O_HLT);
    ena = 1'b0;
    cyc("halted_ena0", ST_HALTED, O_HLT);
    ena = 1'b1;
    cyc("halted_ena1", ST_HALTED, O_HLT);
    opcode = OP_LDA;
    cyc("halted_op", ST_HALTED, O_HLT);
    rst_n = 1'b0;
    #1;
    chk("halt_rst_async", ST_IDLE, 8'h00);
    ena = 1'b0;
    cyc("halt_rst_hold", ST_IDLE, 8'h00);
    rst_n = 1'b1;
    cyc("post_halt_idle", ST_IDLE, 8'h00);
    ena = 1'b1;

    // Reset in the middle of an instruction, then a clean restart.
    opcode = OP_JMP;
    cyc("mid_s0", ST_S0, O_FETCH);
    cyc("mid_s1", ST_S1, O_FETCH);
    cyc("mid_s2", ST_S2, 8'h00);
    cyc("mid_s3", ST_S3, 8'h00);
    cyc("mid_s4", ST_S4, O_PC);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_async", ST_IDLE, 8'h00);
    cyc("mid_rst_hold", ST_IDLE, 8'h00);
    rst_n = 1'b1;
    instr("lda_after_rst", OP_LDA, O_RD, O_RD | O_ACC, O_RD, 8'h00, 1'b0, 1'b0, 1'b0);
    cyc("wrap_s0", ST_S0, O_FETCH);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_controller.md
CPU_CONTROLLER -- requirements
Module: cpu_controller

Interface
REQ-001 SHALL have parameter OP_W, default 3, meaning opcode width.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on posedge.
REQ-003 SHALL have port rst_n, input, 1, reset: asynchronous and active-low.
REQ-004 SHALL have port ena, input, 1, run enable from clock/start logic.
REQ-005 SHALL have port opcode, input, OP_W, current opcode held by the instruction register.
REQ-006 SHALL have port zero, input, 1, accumulator-is-zero flag.
REQ-007 SHALL have outputs, each 1 bit: inc_pc (PC += 1), load_ir (IR captures bus byte), rd (memory read), wr (memory write), load_acc (accumulator load), load_pc (PC load from IR address), datactl_ena (drive accumulator onto bus) and halt (machine stopped).

Function
REQ-008 SHALL encode opcodes as HLT=000, SKZ=001, ADD=010, ANDD=011, XORR=100, LDA=101, STO=110, JMP=111; ALU-class = ADD, ANDD, XORR, LDA.
REQ-009 SHALL implement FSM states IDLE, S0..S7 and HALTED; transitions: IDLE->S0 when ena=1 else stay; Sn->Sn+1 unconditionally for n=0..6; S7->S0 if ena=1 else IDLE.
REQ-010 SHALL take S3->HALTED instead of S4 when opcode=HLT; HALTED is sticky until rst_n low, regardless of ena.
REQ-011 SHALL sample ena only in IDLE and S7; ena deassertion mid-instruction completes that instruction.
REQ-012 SHALL make outputs a function of current state (plus opcode/zero_q from S3 on), valid for the whole cycle the FSM is in that state; unlisted outputs are 0.
REQ-013 SHALL assert in S0: load_ir, rd, inc_pc (opcode/high-address byte); in S1: load_ir, rd, inc_pc (low-address byte); in S2: nothing (IR settles).
REQ-014 SHALL assert nothing in S3 for non-HLT opcodes; in HALTED only halt=1.
REQ-015 SHALL assert in S4: rd for ALU-class; datactl_ena for STO; load_pc for JMP.
REQ-016 SHALL assert in S5: rd and load_acc for ALU-class; datactl_ena for STO; load_pc for JMP; inc_pc for SKZ when zero_q=1.
REQ-017 SHALL assert in S6: datactl_ena and wr for STO; rd for ALU-class.
REQ-018 SHALL assert in S7: datactl_ena for STO; inc_pc for SKZ when zero_q=1.
REQ-019 SHALL register zero into zero_q on the S4->S5 edge; a zero change after S4 does not affect the current SKZ.
REQ-020 SHALL never assert rd and wr in the same cycle, nor wr without datactl_ena.
REQ-021 SHALL decode an out-of-range state as IDLE-equivalent (all outputs 0) and go to IDLE next cycle.

Reset
REQ-022 SHALL, while rst_n=0, force state IDLE, zero_q=0 and all outputs 0, asynchronously.
REQ-023 SHALL, on rst_n release mid-instruction or in HALTED, restart from IDLE and fetch at S0 on the first ena=1 edge.

Structure
REQ-024 SHALL take opcode constants and state encodings from the shared CPU definitions header, also used by the instruction register and ALU.
REQ-025 SHALL be a single module with no sub-module; the next-state logic and the output decode are separate always blocks.

Verification
REQ-026 SHALL check: reset with ena=1 -> all outputs 0, then S0 on the first edge after release with load_ir=rd=inc_pc=1 for exactly 2 cycles.
REQ-027 SHALL check: opcode=LDA -> rd high in S4..S6, load_acc only in S5, 8 cycles per instruction, next S0 after S7.
REQ-028 SHALL check: opcode=STO -> datactl_ena in S4..S7, wr only in S6, rd never high in S4..S7.
REQ-029 SHALL check: opcode=SKZ with zero=1 at S4 -> inc_pc in S5 and S7; with zero=0 at S4 and zero=1 at S6 -> no inc_pc after S1.
REQ-030 SHALL check: opcode=JMP -> load_pc in S4 and S5; opcode=HLT -> halt=1 from the cycle after S3 onward with ena toggling, cleared only by rst_n.
REQ-031 SHALL check: ena dropped in S2 -> instruction completes through S7, then IDLE with outputs 0; ena re-asserted -> S0 next edge.
